// File: rtl/memory_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : memory_responder_pkg
// Description : Shared types and constants for the memory responder block.
// Revision    : 1.0 - initial release
// ============================================================================
package memory_responder_pkg;

  // Default widths used by the CPU-side address/data path.
  localparam int WORD_SIZE_DEF  = 32;
  localparam int ADDR_WIDTH_DEF = 20;

  // Transaction sequencing states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    ACCESS  = 2'd2,
    RESPOND = 2'd3
  } state_t;

  // Number of index bits needed to address 'depth' words (at least one).
  function automatic int index_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/memory_array.sv
`default_nettype none
// ============================================================================
// Module      : memory_array
// Description : Single-port synchronous word array with write enable and a
//               registered read port. Contents are not affected by reset.
// Revision    : 1.0 - initial release
// ============================================================================
module memory_array #(
  parameter int WORD_SIZE   = 32,
  parameter int DEPTH       = 1024,
  parameter int INDEX_WIDTH = 10
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   write_enable,
  input  logic                   read_enable,
  input  logic [INDEX_WIDTH-1:0] index,
  input  logic [WORD_SIZE-1:0]   write_data,
  output logic [WORD_SIZE-1:0]   read_data
);

  logic [WORD_SIZE-1:0] r_mem [DEPTH];
  logic [WORD_SIZE-1:0] r_read_data;

  // Storage write; deliberately has no reset so contents survive it.
  always_ff @(posedge clock) begin
    if (write_enable) begin
      r_mem[index] <= write_data;
    end
  end

  // Registered read port; only updates on an explicit read.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_read_data <= '0;
    end else if (read_enable) begin
      r_read_data <= r_mem[index];
    end
  end

  assign read_data = r_read_data;

endmodule
`default_nettype wire

// File: rtl/memory_responder.sv
`default_nettype none
// ============================================================================
// Module      : memory_responder
// Description : Memory-side responder for the CPU address/data path. Captures
//               a request over a four-phase req/ack handshake, waits a fixed
//               number of cycles, accesses the internal array and acknowledges.
//               Addresses at or beyond DEPTH are flagged with error.
// Revision    : 1.0 - initial release
// ============================================================================
module memory_responder
  import memory_responder_pkg::*;
#(
  parameter int WORD_SIZE   = WORD_SIZE_DEF,
  parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF,
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [WORD_SIZE-1:0]  data_in,
  input  logic                  req,
  input  logic                  write,
  output logic [WORD_SIZE-1:0]  data_out,
  output logic                  ack,
  output logic                  busy,
  output logic                  error
);

  localparam int IDX_W = index_width(DEPTH);
  localparam int CNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

  // DEPTH extended by one bit so the range compare is exact on the full
  // address width even when DEPTH equals 2**ADDR_WIDTH.
  localparam logic [ADDR_WIDTH:0] c_depth_ext = (ADDR_WIDTH + 1)'(DEPTH);

  state_t                r_state;
  state_t                w_next_state;
  logic [CNT_W-1:0]      r_count;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [WORD_SIZE-1:0]  r_wdata;
  logic                  r_write;
  logic [WORD_SIZE-1:0]  r_data_out;
  logic                  r_ack;
  logic                  r_busy;
  logic                  r_error;

  logic                  w_capture;
  logic                  w_access;
  logic                  w_in_range;
  logic                  w_mem_we;
  logic                  w_mem_re;
  logic [WORD_SIZE-1:0]  w_rd_data;

  assign w_capture  = (r_state == IDLE) && req;
  assign w_access   = (r_state == ACCESS);
  assign w_in_range = ({1'b0, r_addr} < c_depth_ext);
  assign w_mem_we   = w_access && r_write && w_in_range;
  assign w_mem_re   = w_access && !r_write && w_in_range;

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode for the request sequencer.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (req) begin
          w_next_state = (WAIT_STATES == 0) ? ACCESS : WAIT;
        end
      end
      WAIT: begin
        if (r_count <= CNT_W'(1)) begin
          w_next_state = ACCESS;
        end
      end
      ACCESS: begin
        w_next_state = RESPOND;
      end
      RESPOND: begin
        if (!req) begin
          w_next_state = IDLE;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Holding registers, wait counter and handshake/status outputs. ack rises
  // one edge after RESPOND is entered so the registered array read can be
  // folded into data_out on that same edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_count    <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_write    <= 1'b0;
      r_data_out <= '0;
      r_ack      <= 1'b0;
      r_busy     <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      if (w_capture) begin
        r_addr  <= address;
        r_wdata <= data_in;
        r_write <= write;
        r_busy  <= 1'b1;
        r_error <= 1'b0;
        r_count <= CNT_W'(WAIT_STATES);
      end

      if (r_state == WAIT) begin
        r_count <= r_count - CNT_W'(1);
      end

      if (w_access && !w_in_range) begin
        r_data_out <= '0;
        r_error    <= 1'b1;
      end

      if (r_state == RESPOND) begin
        if (req) begin
          r_ack <= 1'b1;
          if (!r_ack && !r_write && w_in_range) begin
            r_data_out <= w_rd_data;
          end
        end else begin
          r_ack  <= 1'b0;
          r_busy <= 1'b0;
        end
      end
    end
  end

  memory_array #(
    .WORD_SIZE   (WORD_SIZE),
    .DEPTH       (DEPTH),
    .INDEX_WIDTH (IDX_W)
  ) u_memory_array (
    .clock        (clock),
    .reset        (reset),
    .write_enable (w_mem_we),
    .read_enable  (w_mem_re),
    .index        (r_addr[IDX_W-1:0]),
    .write_data   (r_wdata),
    .read_data    (w_rd_data)
  );

  assign data_out = r_data_out;
  assign ack      = r_ack;
  assign busy     = r_busy;
  assign error    = r_error;

endmodule
`default_nettype wire

// File: tb/tb_memory_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_memory_responder
// Description : Self-checking bench for memory_responder: a WAIT_STATES=2
//               instance driven by directed and random transactions checked
//               against an array model, plus a WAIT_STATES=0 instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_memory_responder;

  logic        clock = 1'b0;
  logic        reset = 1'b1;

  logic [19:0] address = '0;
  logic [31:0] data_in = '0;
  logic        req     = 1'b0;
  logic        write   = 1'b0;
  logic [31:0] data_out;
  logic        ack, busy, error;

  logic [19:0] address0 = '0;
  logic [31:0] data_in0 = '0;
  logic        req0     = 1'b0;
  logic        write0   = 1'b0;
  logic [31:0] data_out0;
  logic        ack0, busy0, error0;

  int checks = 0;
  int errors = 0;

  // Reference model: word store, last returned data word, written addresses.
  logic [31:0] model_mem [0:1023];
  logic [31:0] model_dout = '0;
  logic [19:0] written [$];

  always #5 clock = ~clock;

  memory_responder #(.WORD_SIZE(32), .ADDR_WIDTH(20), .DEPTH(1024), .WAIT_STATES(2)) dut (
    .clock(clock), .reset(reset), .address(address), .data_in(data_in), .req(req),
    .write(write), .data_out(data_out), .ack(ack), .busy(busy), .error(error)
  );

  memory_responder #(.WORD_SIZE(32), .ADDR_WIDTH(20), .DEPTH(1024), .WAIT_STATES(0)) dut0 (
    .clock(clock), .reset(reset), .address(address0), .data_in(data_in0), .req(req0),
    .write(write0), .data_out(data_out0), .ack(ack0), .busy(busy0), .error(error0)
  );

  // One full handshake on the WAIT_STATES=2 instance, checked against the model.
  task automatic txn(input logic wr, input logic [19:0] a, input logic [31:0] d,
                     input bit disturb, output logic [31:0] rd, output logic er);
    int lat;
    int hold;
    logic [31:0] exp_d;
    logic exp_e;
    exp_e = (a >= 20'd1024);
    if (exp_e)   exp_d = 32'h0;
    else if (wr) exp_d = model_dout;
    else         exp_d = model_mem[a[9:0]];
    if (!exp_e && wr) begin
      model_mem[a[9:0]] = d;
      written.push_back(a);
    end
    model_dout = exp_d;

    @(negedge clock);
    req = 1'b1; write = wr; address = a; data_in = d;
    @(posedge clock); #1;
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL busy_after_capture: got %b expected 1", busy);
    end
    if (disturb) begin
      address = a ^ 20'h0000E; data_in = ~d; write = ~wr;
    end
    lat = 0;
    while (ack !== 1'b1 && lat < 40) begin
      @(posedge clock); #1; lat++;
    end
    checks++;
    if (lat !== 4) begin
      errors++; $display("FAIL ack_latency addr=%h: got %0d edges expected 4", a, lat);
    end
    checks++;
    if (error !== exp_e) begin
      errors++; $display("FAIL error_flag addr=%h: got %b expected %b", a, error, exp_e);
    end
    checks++;
    if (data_out !== exp_d) begin
      errors++; $display("FAIL data_out addr=%h wr=%b: got %h expected %h", a, wr, data_out, exp_d);
    end
    rd = data_out;
    er = error;
    hold = $urandom_range(0, 3);
    for (int i = 0; i < hold; i++) begin
      @(posedge clock); #1;
      checks++;
      if (ack !== 1'b1 || busy !== 1'b1) begin
        errors++; $display("FAIL ack_hold: got ack=%b busy=%b expected 1 1", ack, busy);
      end
    end
    @(negedge clock);
    req = 1'b0; write = 1'b0;
    @(posedge clock); #1;
    checks++;
    if (ack !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL release: got ack=%b busy=%b expected 0 0", ack, busy);
    end
    checks++;
    if (error !== exp_e) begin
      errors++; $display("FAIL error_kept_in_idle: got %b expected %b", error, exp_e);
    end
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    logic er;
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clock); #1;
      checks++;
      if ({ack, busy, error} !== 3'b000 || data_out !== 32'h0) begin
        errors++; $display("FAIL reset_outputs: got ack=%b busy=%b error=%b data=%h expected all 0",
                           ack, busy, error, data_out);
      end
    end
    @(negedge clock);
    reset = 1'b0;
    model_dout = 32'h0;
    txn(1'b1, 20'd5, 32'hDEADBEEF, 1'b0, rd, er);
    checks++;
    if (er !== 1'b0) begin
      errors++; $display("FAIL first_write_error: got %b expected 0", er);
    end
  endtask

  task automatic test_write_read();
    logic [31:0] rd;
    logic er;
    txn(1'b0, 20'd5, 32'h0, 1'b0, rd, er);
    checks++;
    if (rd !== 32'hDEADBEEF) begin
      errors++; $display("FAIL read_back_5: got %h expected deadbeef", rd);
    end
  endtask

  task automatic test_out_of_range();
    logic [31:0] rd;
    logic er;
    txn(1'b1, 20'd976, 32'h55, 1'b0, rd, er);
    txn(1'b0, 20'd1024, 32'h0, 1'b0, rd, er);
    checks++;
    if (er !== 1'b1 || rd !== 32'h0) begin
      errors++; $display("FAIL oor_read: got error=%b data=%h expected 1 00000000", er, rd);
    end
    txn(1'b1, 20'd2000, 32'h1, 1'b0, rd, er);
    checks++;
    if (er !== 1'b1) begin
      errors++; $display("FAIL oor_write_error: got %b expected 1", er);
    end
    txn(1'b0, 20'd976, 32'h0, 1'b0, rd, er);
    checks++;
    if (er !== 1'b0 || rd !== 32'h55) begin
      errors++; $display("FAIL alias_976: got error=%b data=%h expected 0 00000055", er, rd);
    end
  endtask

  task automatic test_hold_off();
    logic [31:0] rd;
    logic er;
    txn(1'b1, 20'd7, 32'hA5A5A5A5, 1'b0, rd, er);
    txn(1'b1, 20'd9, 32'h99999999, 1'b0, rd, er);
    txn(1'b0, 20'd7, 32'h0, 1'b1, rd, er);
    checks++;
    if (rd !== 32'hA5A5A5A5) begin
      errors++; $display("FAIL hold_off: got %h expected a5a5a5a5", rd);
    end
    txn(1'b0, 20'd9, 32'h0, 1'b0, rd, er);
    checks++;
    if (rd !== 32'h99999999) begin
      errors++; $display("FAIL hold_off_no_write: got %h expected 99999999", rd);
    end
  endtask

  task automatic test_reset_mid_write();
    logic [31:0] rd;
    logic er;
    txn(1'b1, 20'd3, 32'h0, 1'b0, rd, er);
    @(negedge clock);
    req = 1'b1; write = 1'b1; address = 20'd3; data_in = 32'h1234;
    @(posedge clock); #1;
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock); #1;
    checks++;
    if ({ack, busy, error} !== 3'b000 || data_out !== 32'h0) begin
      errors++; $display("FAIL mid_reset_outputs: got ack=%b busy=%b error=%b data=%h expected all 0",
                         ack, busy, error, data_out);
    end
    @(negedge clock);
    reset = 1'b0; req = 1'b0; write = 1'b0;
    model_dout = 32'h0;
    @(posedge clock); #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL mid_reset_idle: got busy=%b expected 0", busy);
    end
    txn(1'b0, 20'd3, 32'h0, 1'b0, rd, er);
    checks++;
    if (rd !== 32'h0) begin
      errors++; $display("FAIL dropped_write: got %h expected 00000000", rd);
    end
  endtask

  task automatic test_random();
    logic [31:0] rd;
    logic er;
    int kind;
    logic [19:0] a;
    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 9);
      if (kind >= 8)                            a = 20'($urandom_range(1024, 20'hFFFFF));
      else if (kind >= 4 && written.size() > 0) a = written[$urandom_range(0, written.size() - 1)];
      else                                      a = 20'($urandom_range(0, 1023));
      if (kind >= 4 && kind <= 7 && written.size() == 0) kind = 0;
      txn((kind <= 3 || kind == 9), a, 32'($urandom), ($urandom_range(0, 1) == 1), rd, er);
    end
  endtask

  task automatic test_ws0();
    logic        wr_t [3] = '{1'b1, 1'b0, 1'b0};
    logic [19:0] a_t  [3] = '{20'd12, 20'd12, 20'hFFFFF};
    logic [31:0] d_t  [3] = '{32'hCAFEF00D, 32'h0, 32'h0};
    logic [31:0] ed_t [3] = '{32'h0, 32'hCAFEF00D, 32'h0};
    logic        ee_t [3] = '{1'b0, 1'b0, 1'b1};
    int lat;
    for (int t = 0; t < 3; t++) begin
      @(negedge clock);
      req0 = 1'b1; write0 = wr_t[t]; address0 = a_t[t]; data_in0 = d_t[t];
      @(posedge clock); #1;
      lat = 0;
      while (ack0 !== 1'b1 && lat < 40) begin
        @(posedge clock); #1; lat++;
      end
      checks++;
      if (lat !== 2) begin
        errors++; $display("FAIL ws0_latency t=%0d: got %0d edges expected 2", t, lat);
      end
      checks++;
      if (data_out0 !== ed_t[t] || error0 !== ee_t[t]) begin
        errors++; $display("FAIL ws0_result t=%0d: got data=%h error=%b expected %h %b",
                           t, data_out0, error0, ed_t[t], ee_t[t]);
      end
      for (int i = 0; i < 5; i++) begin
        @(posedge clock); #1;
        checks++;
        if (ack0 !== 1'b1 || busy0 !== 1'b1) begin
          errors++; $display("FAIL ws0_hold t=%0d: got ack=%b busy=%b expected 1 1", t, ack0, busy0);
        end
      end
      @(negedge clock);
      req0 = 1'b0;
      @(posedge clock); #1;
      checks++;
      if (ack0 !== 1'b0 || busy0 !== 1'b0) begin
        errors++; $display("FAIL ws0_release t=%0d: got ack=%b busy=%b expected 0 0", t, ack0, busy0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_out_of_range();
    test_hold_off();
    test_reset_mid_write();
    test_ws0();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
